// File: rtl/result_collector_pkg.sv
// Shared types and sizing for the result collector that drains a 3x3 array.
// The optional parity output is controlled by the RESULT_COLLECTOR_PARITY_EN macro.
package result_collector_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      STREAM = 2'd2
   } state_t;

   localparam int NUM_ELEMS = 9;
   localparam int IDX_W     = 4;
   localparam int CNT_W     = 8;

endpackage

// File: rtl/result_collector_if.sv
// Result stream between the collector (master) and its consumer (slave).
// OUT_PARITY exists only when RESULT_COLLECTOR_PARITY_EN is defined.
interface result_collector_if
   import result_collector_pkg::*;
#(
   parameter int WIDTH = 4
);

   logic [2*WIDTH:0]  out_data;
   logic [IDX_W-1:0]  out_idx;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
`ifdef RESULT_COLLECTOR_PARITY_EN
   logic              out_parity;

   modport master (output out_data, out_idx, out_valid, out_last, out_parity, input out_ready);
   modport slave  (input out_data, out_idx, out_valid, out_last, out_parity, output out_ready);
`else
   modport master (output out_data, out_idx, out_valid, out_last, input out_ready);
   modport slave  (input out_data, out_idx, out_valid, out_last, output out_ready);
`endif

endinterface

// File: rtl/result_collector_drain_timer.sv
// Loadable up-counter whose flag marks the edge that reaches DRAIN_DELAY cycles
// after the load, i.e. the cycle the array results are stable.
module drain_timer
   import result_collector_pkg::*;
#(
   parameter int DRAIN_DELAY = 7
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic done
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

   // The load edge itself is cycle zero, so the next edge that counts is the one after DRAIN_DELAY-1.
   assign done = (count == CNT_W'(DRAIN_DELAY - 1));

endmodule

// File: rtl/result_collector.sv
// Waits for the 3x3 array to drain, snapshots its nine results and streams them
// out row-major. Define RESULT_COLLECTOR_PARITY_EN to add OUT_PARITY.
module result_collector
   import result_collector_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int DRAIN_DELAY = 7
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2*WIDTH:0]   in_1x1,
   input  logic [2*WIDTH:0]   in_1x2,
   input  logic [2*WIDTH:0]   in_1x3,
   input  logic [2*WIDTH:0]   in_2x1,
   input  logic [2*WIDTH:0]   in_2x2,
   input  logic [2*WIDTH:0]   in_2x3,
   input  logic [2*WIDTH:0]   in_3x1,
   input  logic [2*WIDTH:0]   in_3x2,
   input  logic [2*WIDTH:0]   in_3x3,
   output logic               busy,
   output logic               clear_out,
   result_collector_if.master stream
);

   localparam int RES_W = 2*WIDTH + 1;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q;
   logic [RES_W-1:0] buffer [NUM_ELEMS];
   logic [RES_W-1:0] in_vec [NUM_ELEMS];
   logic             timer_load, timer_en, timer_done;
   logic             capture, xfer, at_last, valid;

   assign in_vec[0] = in_1x1;
   assign in_vec[1] = in_1x2;
   assign in_vec[2] = in_1x3;
   assign in_vec[3] = in_2x1;
   assign in_vec[4] = in_2x2;
   assign in_vec[5] = in_2x3;
   assign in_vec[6] = in_3x1;
   assign in_vec[7] = in_3x2;
   assign in_vec[8] = in_3x3;

   drain_timer #(
      .DRAIN_DELAY (DRAIN_DELAY)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (timer_load),
      .en    (timer_en),
      .done  (timer_done)
   );

   assign valid   = (state_q == STREAM);
   assign at_last = (idx_q == IDX_W'(NUM_ELEMS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // START is only looked at in IDLE, so restarts while busy simply fall through.
   always_comb begin
      state_d    = state_q;
      timer_load = 1'b0;
      timer_en   = 1'b0;
      capture    = 1'b0;
      xfer       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = WAIT;
               timer_load = 1'b1;
            end
         end
         WAIT: begin
            timer_en = 1'b1;
            if (timer_done) begin
               state_d = STREAM;
               capture = 1'b1;
            end
         end
         STREAM: begin
            if (stream.out_ready) begin
               xfer = 1'b1;
               if (at_last) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= '0;
         clear_out <= 1'b0;
         for (int i = 0; i < NUM_ELEMS; i++) begin
            buffer[i] <= '0;
         end
      end else begin
         clear_out <= capture;
         if (capture) begin
            idx_q <= '0;
            for (int i = 0; i < NUM_ELEMS; i++) begin
               buffer[i] <= in_vec[i];
            end
         end else if (xfer) begin
            idx_q <= at_last ? '0 : idx_q + IDX_W'(1);
         end
      end
   end

   // Data is forced to zero outside STREAM so the outputs read as their reset values when idle.
   assign stream.out_data  = valid ? buffer[idx_q] : '0;
   assign stream.out_idx   = idx_q;
   assign stream.out_valid = valid;
   assign stream.out_last  = valid && at_last;
   assign busy             = (state_q != IDLE);

`ifdef RESULT_COLLECTOR_PARITY_EN
   assign stream.out_parity = ^stream.out_data;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: full-rate, back-pressured, restart, reset-abort
// and input-change streams of the 3x3 product of [[1,2,3],[4,5,6],[7,8,9]] with itself.
module tb_result_collector;

`ifdef RESULT_COLLECTOR_PARITY_EN
   localparam int DD = 1;
`else
   localparam int DD = 7;
`endif
   localparam int W  = 4;

   logic clk;
   logic rst_n;
   logic start;
   logic [2*W:0] in_1x1, in_1x2, in_1x3, in_2x1, in_2x2, in_2x3, in_3x1, in_3x2, in_3x3;
   logic busy;
   logic clear_out;

   int n_checks;
   int n_errors;

   logic [2*W:0] expected [9];

   result_collector_if #(.WIDTH(W)) bus ();

   result_collector #(
      .WIDTH       (W),
      .DRAIN_DELAY (DD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_1x1    (in_1x1),
      .in_1x2    (in_1x2),
      .in_1x3    (in_1x3),
      .in_2x1    (in_2x1),
      .in_2x2    (in_2x2),
      .in_2x3    (in_2x3),
      .in_3x1    (in_3x1),
      .in_3x2    (in_3x2),
      .in_3x3    (in_3x3),
      .busy      (busy),
      .clear_out (clear_out),
      .stream    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected_val);
      n_checks++;
      if (observed !== expected_val) begin
         n_errors++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected_val);
      end
   endtask

   task automatic apply_stimulus(input bit zero);
      in_1x1 = zero ? '0 : 9'd30;
      in_1x2 = zero ? '0 : 9'd36;
      in_1x3 = zero ? '0 : 9'd42;
      in_2x1 = zero ? '0 : 9'd66;
      in_2x2 = zero ? '0 : 9'd81;
      in_2x3 = zero ? '0 : 9'd96;
      in_3x1 = zero ? '0 : 9'd102;
      in_3x2 = zero ? '0 : 9'd126;
      in_3x3 = zero ? '0 : 9'd150;
   endtask

   // Called at a negedge; returns at the negedge just after the capture edge.
   task automatic launch(input bit restart);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check_output("busy_after_start", 32'(busy), 1);
      check_output("valid_after_start", 32'(bus.out_valid), 0);
      for (int c = 1; c < DD; c++) begin
         start = restart;
         @(negedge clk);
         check_output("valid_in_wait", 32'(bus.out_valid), 0);
         check_output("clear_in_wait", 32'(clear_out), 0);
         check_output("busy_in_wait", 32'(busy), 1);
      end
      start = 1'b0;
      @(negedge clk);
      check_output("valid_at_capture", 32'(bus.out_valid), 1);
      check_output("clear_at_capture", 32'(clear_out), 1);
      check_output("idx_at_capture", 32'(bus.out_idx), 0);
   endtask

   // mode 0: ready held, 1: ready 1,0,0 pattern, 2: restarts while streaming,
   // 3: inputs zeroed after capture, 4: reset during the 4th transfer
   task automatic stream_phase(input int mode);
      int n;
      int cyc;
      bit rdy;
      n = 0;
      for (cyc = 0; cyc < 60 && n < 9; cyc++) begin
         if (mode == 3 && cyc == 0) apply_stimulus(1'b1);
         rdy = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
         bus.out_ready = rdy;
         if (mode == 2) start = (cyc == 2) || (n == 8);
         if (mode == 4 && n == 3) begin
            rst_n = 1'b0;
            #1;
            check_output("valid_in_reset", 32'(bus.out_valid), 0);
            check_output("busy_in_reset", 32'(busy), 0);
            check_output("data_in_reset", 32'(bus.out_data), 0);
            check_output("last_in_reset", 32'(bus.out_last), 0);
            break;
         end
         check_output("valid", 32'(bus.out_valid), 1);
         check_output("data", 32'(bus.out_data), 32'(expected[n]));
         check_output("idx", 32'(bus.out_idx), n);
         check_output("last", 32'(bus.out_last), (n == 8) ? 1 : 0);
`ifdef RESULT_COLLECTOR_PARITY_EN
         check_output("parity", 32'(bus.out_parity), 32'(^expected[n]));
`endif
         if (cyc == 1) check_output("clear_one_cycle", 32'(clear_out), 0);
         if (mode == 2) check_output("busy_restart", 32'(busy), 1);
         @(posedge clk);
         if (rdy) n++;
         @(negedge clk);
      end
      start = 1'b0;
      if (mode != 4) begin
         check_output("xfer_count", n, 9);
         check_output("valid_after_last", 32'(bus.out_valid), 0);
         check_output("busy_after_last", 32'(busy), 0);
         check_output("idx_after_last", 32'(bus.out_idx), 0);
         if (mode == 0) check_output("full_rate_cycles", cyc, 9);
         if (mode == 2) begin
            @(negedge clk);
            check_output("busy_ignored_last_start", 32'(busy), 0);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      expected[0] = 9'd30;  expected[1] = 9'd36;  expected[2] = 9'd42;
      expected[3] = 9'd66;  expected[4] = 9'd81;  expected[5] = 9'd96;
      expected[6] = 9'd102; expected[7] = 9'd126; expected[8] = 9'd150;
      rst_n = 1'b0;
      start = 1'b0;
      bus.out_ready = 1'b0;
      apply_stimulus(1'b1);
      repeat (2) @(negedge clk);
      check_output("rst_valid", 32'(bus.out_valid), 0);
      check_output("rst_busy", 32'(busy), 0);
      check_output("rst_clear", 32'(clear_out), 0);
      check_output("rst_data", 32'(bus.out_data), 0);
      check_output("rst_idx", 32'(bus.out_idx), 0);
      check_output("rst_last", 32'(bus.out_last), 0);

      apply_stimulus(1'b0);
      rst_n = 1'b1;
      $display("[TB] full-rate stream");
      launch(1'b0);
      stream_phase(0);

      $display("[TB] back-pressured stream");
      launch(1'b0);
      stream_phase(1);

      $display("[TB] restart attempts while busy");
      launch(1'b1);
      stream_phase(2);

      $display("[TB] inputs zeroed after capture");
      launch(1'b0);
      stream_phase(3);
      apply_stimulus(1'b0);

      $display("[TB] reset during stream");
      launch(1'b0);
      stream_phase(4);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < DD + 2; c++) begin
         @(negedge clk);
         check_output("no_clear_after_abort", 32'(clear_out), 0);
         check_output("no_valid_after_abort", 32'(bus.out_valid), 0);
      end
      launch(1'b0);
      stream_phase(0);

      $display("[TB] reset during wait");
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      check_output("busy_wait_reset", 32'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < DD + 2; c++) begin
         @(negedge clk);
         check_output("no_clear_wait_abort", 32'(clear_out), 0);
         check_output("no_valid_wait_abort", 32'(bus.out_valid), 0);
      end
      launch(1'b0);
      stream_phase(0);

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the operand width of the 3x3 array; result width is 2*WIDTH+1.
REQ-002 The block SHALL have parameter DRAIN_DELAY, default 7, the number of cycles from START to stable array results; legal range 1..255.
REQ-003 The block SHALL have port CLK, input, 1, the single clock, rising edge.
REQ-004 The block SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port START, input, 1, a one-cycle pulse issued with the array launch.
REQ-006 The block SHALL have ports IN_1x1..IN_3x3, input, 2*WIDTH+1 each, the nine array accumulator results.
REQ-007 The block SHALL have port OUT_DATA, output, 2*WIDTH+1, the current streamed result.
REQ-008 The block SHALL have port OUT_IDX, output, 4, the row-major element index, 0..8.
REQ-009 The block SHALL have ports OUT_VALID (output, 1), OUT_READY (input, 1) and OUT_LAST (output, 1), the stream handshake.
REQ-010 The block SHALL have port BUSY, output, 1, high whenever the state is not IDLE.
REQ-011 The block SHALL have port CLEAR_OUT, output, 1, a one-cycle pulse that tells the array to clear its accumulators.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, WAIT and STREAM.
REQ-013 IDLE: START sampled high at edge k SHALL move the FSM to WAIT and load the delay counter to 0.
REQ-014 WAIT: the counter SHALL increment each cycle, and at edge k+DRAIN_DELAY all nine IN_* values SHALL be captured into a buffer, the FSM SHALL enter STREAM and OUT_IDX SHALL be set to 0.
REQ-015 CLEAR_OUT SHALL be high for exactly the one cycle following the capture edge.
REQ-016 STREAM: OUT_VALID SHALL be 1 and OUT_DATA SHALL equal buffer[OUT_IDX] in row-major order (1x1,1x2,1x3,2x1,...,3x3).
REQ-017 A transfer SHALL occur on an edge where OUT_VALID and OUT_READY are both high, and OUT_IDX SHALL then increment by 1.
REQ-018 While OUT_READY is low, OUT_DATA, OUT_IDX and OUT_LAST SHALL remain stable.
REQ-019 OUT_LAST SHALL equal OUT_VALID and (OUT_IDX==8).
REQ-020 A transfer with OUT_IDX==8 SHALL return the FSM to IDLE, with OUT_VALID low in the next cycle and OUT_IDX reset to 0.
REQ-021 START outside IDLE SHALL be ignored, including in the cycle of the last transfer.
REQ-022 IN_* changes after the capture edge SHALL NOT affect the streamed data.
REQ-023 Full throughput SHALL be one result per cycle, so 9 results take 9 consecutive cycles with OUT_READY held at 1.
REQ-024 Data SHALL pass unsigned with no truncation: OUT_DATA is exactly the captured 2*WIDTH+1 bits.

Reset
REQ-025 RST low SHALL asynchronously force: state IDLE, counter 0, OUT_IDX 0, OUT_VALID 0, OUT_LAST 0, BUSY 0, CLEAR_OUT 0, OUT_DATA 0 and the buffer cleared.
REQ-026 Reset asserted mid-WAIT or mid-STREAM SHALL abort the operation without emitting further transfers or a CLEAR_OUT pulse.
REQ-027 After reset release, the first START SHALL be accepted at the first rising edge at which RST is high.

Configuration
REQ-028 When RESULT_COLLECTOR_PARITY_EN is defined, the block SHALL add output OUT_PARITY, 1 bit, the even-parity bit of OUT_DATA (XOR of all bits), with the same timing as OUT_DATA and reset value 0.
REQ-029 When RESULT_COLLECTOR_PARITY_EN is undefined, the OUT_PARITY port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Package result_collector_pkg SHALL hold the state enum (IDLE, WAIT, STREAM), NUM_ELEMS=9, IDX_W=4 and CNT_W=8.
REQ-031 The design SHALL contain one sub-module, drain_timer, a loadable up-counter with a terminal-count flag at DRAIN_DELAY.

Verification
REQ-032 Matrix A=B=[[1,2,3],[4,5,6],[7,8,9]] on IN_*, START at edge k, OUT_READY=1 -> results 30,36,42,66,81,96,102,126,150 on edges k+7..k+15; OUT_LAST only with 150; CLEAR_OUT on the cycle after k+7.
REQ-033 Same stimulus with OUT_READY toggled 1,0,0,1,... -> no result dropped or duplicated; OUT_DATA stable while OUT_READY=0; order unchanged.
REQ-034 Second START during WAIT and during STREAM -> ignored; BUSY stays high; exactly 9 transfers occur.
REQ-035 RST pulsed low at the 4th transfer -> OUT_VALID=0 immediately; no CLEAR_OUT; next START produces a full clean 9-result stream.
REQ-036 IN_* changed to all-zero one cycle after capture -> the stream still carries 30..150.
REQ-037 With RESULT_COLLECTOR_PARITY_EN defined and DRAIN_DELAY=1 -> capture at k+1; OUT_PARITY=0 for 30 and 1 for 81.
